// File: rtl/joy_pkg.sv
// Shared types and constants for the DB15 joystick serial transmitter.
package joy_pkg;

   localparam int DB15_WORD_BITS = 12;

   // Bit positions within a 12-bit player word, {L,S,F,E,D,C,B,A,U,D,L,R}.
   localparam int BTN_RIGHT = 0;
   localparam int BTN_LEFT  = 1;
   localparam int BTN_DOWN  = 2;
   localparam int BTN_UP    = 3;
   localparam int BTN_A     = 4;
   localparam int BTN_B     = 5;
   localparam int BTN_C     = 6;
   localparam int BTN_D     = 7;
   localparam int BTN_E     = 8;
   localparam int BTN_F     = 9;
   localparam int BTN_START = 10;
   localparam int BTN_L     = 11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOADED = 2'd1,
      SHIFT  = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/joy_db15_tx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin plus a one-cycle edge pulse
// taken from the last two synchronized samples.
module sync_edge #(
   parameter int STAGES = 2,
   parameter bit FALL   = 1'b0
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic din,
   output logic lvl,
   output logic pulse
);

   logic [STAGES-1:0] sync_q, sync_d;
   logic              prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], din};
      prev_d = sync_q[STAGES-1];
   end

   // Reset to the idle-high level so releasing reset never fakes an edge.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sync_q <= '1;
         prev_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign lvl   = sync_q[STAGES-1];
   assign pulse = FALL ? (prev_q & ~sync_q[STAGES-1]) : (~prev_q & sync_q[STAGES-1]);

endmodule

// File: rtl/joy_db15_tx.sv
// DB15 joystick transmitter: emulates a 74HC165 chain feeding two 12-bit
// player words to an external reader driving joy_clk / joy_load.
module joy_db15_tx
   import joy_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_BITS  = 24
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [11:0] joystick1,
   input  logic [11:0] joystick2,
   input  logic        joy_clk,
   input  logic        joy_load,
   output logic        joy_data,
   output logic        frame_done,
   output logic        overrun
);

   localparam int CNT_W = $clog2(FRAME_BITS) + 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

   logic clk_rise, clk_lvl_unused;
   logic load_lvl, load_fall_unused;

   sync_edge #(.STAGES(SYNC_STAGES), .FALL(1'b0)) u_clk_sync (
      .clk_sys (clk_sys),
      .reset   (reset),
      .din     (joy_clk),
      .lvl     (clk_lvl_unused),
      .pulse   (clk_rise)
   );

   sync_edge #(.STAGES(SYNC_STAGES), .FALL(1'b1)) u_load_sync (
      .clk_sys (clk_sys),
      .reset   (reset),
      .din     (joy_load),
      .lvl     (load_lvl),
      .pulse   (load_fall_unused)
   );

   state_e                state_q, state_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  overrun_q, overrun_d;
   logic                  frame_done_q, frame_done_d;
   logic                  joy_data_q, joy_data_d;

   // Load is level-sensitive: the falling edge is the first cycle of a low
   // level, and a held-low strobe keeps the snapshot transparent.
   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
      overrun_d    = overrun_q;
      frame_done_d = 1'b0;

      if (!load_lvl) begin
         shreg_d = FRAME_BITS'(~{joystick2, joystick1});
         cnt_d   = '0;
         state_d = LOADED;
      end else if (clk_rise) begin
         case (state_q)
            LOADED, SHIFT: begin
               shreg_d = {1'b1, shreg_q[FRAME_BITS-1:1]};
               cnt_d   = cnt_q + 1'b1;
               if (cnt_q == LAST_BIT) begin
                  state_d      = DONE;
                  frame_done_d = 1'b1;
               end else begin
                  state_d = SHIFT;
               end
            end
            DONE:    overrun_d = 1'b1;
            default: ;
         endcase
      end

      joy_data_d = ((state_d == LOADED) || (state_d == SHIFT)) ? shreg_d[0] : 1'b1;
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= IDLE;
         shreg_q      <= '1;
         cnt_q        <= '0;
         overrun_q    <= 1'b0;
         frame_done_q <= 1'b0;
         joy_data_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         overrun_q    <= overrun_d;
         frame_done_q <= frame_done_d;
         joy_data_q   <= joy_data_d;
      end
   end

   assign joy_data   = joy_data_q;
   assign frame_done = frame_done_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_joy_db15_tx.sv
// Directed bench for joy_db15_tx: frame order, latency, overrun, reset abort,
// load/clock collision and transparent load.
module tb_joy_db15_tx;

   localparam int S  = 2;
   localparam int FB = 24;

   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic [11:0] joystick1 = '0;
   logic [11:0] joystick2 = '0;
   logic        joy_clk = 1'b0;
   logic        joy_load = 1'b1;
   logic        joy_data, frame_done, overrun;

   int checks = 0;
   int errors = 0;
   int fd_cnt = 0;
   logic [FB-1:0] snap;

   joy_db15_tx #(.SYNC_STAGES(S), .FRAME_BITS(FB)) dut (
      .clk_sys    (clk_sys),
      .reset      (reset),
      .joystick1  (joystick1),
      .joystick2  (joystick2),
      .joy_clk    (joy_clk),
      .joy_load   (joy_load),
      .joy_data   (joy_data),
      .frame_done (frame_done),
      .overrun    (overrun)
   );

   always #10 clk_sys = ~clk_sys;

   always @(negedge clk_sys) if (frame_done) fd_cnt++;

   task automatic tick(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rise();
      joy_clk = 1'b1; tick(S + 2);
      joy_clk = 1'b0; tick(S + 2);
   endtask

   task automatic load(input logic [11:0] j1, input logic [11:0] j2);
      joystick1 = j1; joystick2 = j2;
      snap = ~{j2, j1};
      joy_load = 1'b0; tick(S + 2);
      joy_load = 1'b1; tick(S + 2);
   endtask

   task automatic frame(input string tag, input int from);
      for (int i = from; i < FB; i++) begin
         chk(tag, {31'd0, joy_data}, {31'd0, snap[i]});
         rise();
      end
   endtask

   initial begin
      int fd0;
      tick(1);
      chk("rst_data", {31'd0, joy_data}, 32'd1);
      chk("rst_fd", {31'd0, frame_done}, 32'd0);
      chk("rst_ovr", {31'd0, overrun}, 32'd0);
      reset = 1'b0; tick(1);
      chk("post_rst_data", {31'd0, joy_data}, 32'd1);
      chk("post_rst_fd", {31'd0, frame_done}, 32'd0);
      chk("post_rst_ovr", {31'd0, overrun}, 32'd0);

      // Single pressed bit at each end of the frame.
      load(12'h001, 12'h800);
      chk("f1_bit0", {31'd0, joy_data}, 32'd0);
      joy_clk = 1'b1; tick(S);
      chk("lat_before", {31'd0, joy_data}, 32'd0);
      tick(1);
      chk("lat_at", {31'd0, joy_data}, 32'd1);
      tick(1); joy_clk = 1'b0; tick(S + 2);
      chk("f1_fd_mid", fd_cnt, 32'd0);
      frame("f1_bits", 1);
      chk("f1_fd", fd_cnt, 32'd1);
      chk("f1_done_data", {31'd0, joy_data}, 32'd1);
      chk("f1_ovr", {31'd0, overrun}, 32'd0);

      // Extra clocks past the frame end.
      rise();
      chk("ovr_set", {31'd0, overrun}, 32'd1);
      rise(); rise();
      chk("ovr_data", {31'd0, joy_data}, 32'd1);
      chk("ovr_fd", fd_cnt, 32'd1);
      load(12'h0A5, 12'h3C6);
      chk("ovr_sticky", {31'd0, overrun}, 32'd1);
      frame("f2_bits", 0);
      chk("f2_fd", fd_cnt, 32'd2);

      // Reset in mid-frame.
      load(12'h5A3, 12'hC31);
      for (int i = 0; i < 10; i++) rise();
      chk("mid_bit10", {31'd0, joy_data}, {31'd0, snap[10]});
      reset = 1'b1; tick(1); reset = 1'b0;
      chk("abort_data", {31'd0, joy_data}, 32'd1);
      chk("abort_ovr", {31'd0, overrun}, 32'd0);
      tick(S + 2);
      chk("abort_idle", {31'd0, joy_data}, 32'd1);
      chk("abort_fd", fd_cnt, 32'd2);
      rise();
      chk("idle_rise_data", {31'd0, joy_data}, 32'd1);
      chk("idle_rise_ovr", {31'd0, overrun}, 32'd0);
      load(12'h9E7, 12'h16B);
      frame("f3_bits", 0);
      chk("f3_fd", fd_cnt, 32'd3);
      chk("f3_done_data", {31'd0, joy_data}, 32'd1);

      // Load strobe of one cycle coinciding with a clock rise: load wins.
      fd0 = fd_cnt;
      joystick1 = 12'h002; joystick2 = 12'h000;
      snap = ~{joystick2, joystick1};
      joy_load = 1'b0; joy_clk = 1'b1; tick(1);
      joy_load = 1'b1; tick(S + 3);
      chk("coll_data", {31'd0, joy_data}, 32'd1);
      chk("coll_ovr", {31'd0, overrun}, 32'd0);
      joy_clk = 1'b0; tick(S + 2);
      rise();
      chk("coll_bit1", {31'd0, joy_data}, 32'd0);
      chk("coll_fd", fd_cnt, fd0);

      // Transparent load while strobe is held low.
      joystick1 = 12'h000; joy_load = 1'b0; tick(S + 2);
      chk("transp_rel", {31'd0, joy_data}, 32'd1);
      joystick1 = 12'hFFF; tick(S + 1);
      chk("transp_press", {31'd0, joy_data}, 32'd0);
      joy_load = 1'b1; tick(S + 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
